// File: rtl/sram_arb_pkg.sv
// Shared types, widths and the round-robin pick used by the SRAM arbiter.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int MAX_REQ     = 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWN    = 2'd1,
        ARB_SWITCH = 2'd2
    } arb_state_type;

    // First requester at or after ptr, scanning circularly over num_req ports.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] req_vec,
        input logic [2:0]         ptr,
        input int                 num_req
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % num_req;
            if (!found && (k < num_req) && req_vec[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sram_read_tag_pipe.sv
// Delay line of {read issued, owner id}; routes returning SRAM read data
// to the requester that issued the read, independent of later grant changes.
module sram_read_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 2,
    parameter int ID_W         = 2
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic               issue_i,
    input  logic [ID_W-1:0]    id_i,
    output logic [NUM_REQ-1:0] read_valid_o
);

    localparam int LAST = READ_LATENCY - 1;

    logic [READ_LATENCY-1:0]           valid_q;
    logic [READ_LATENCY-1:0][ID_W-1:0] id_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q[0] <= issue_i;
            id_q[0]    <= id_i;
            for (int s = 1; s < READ_LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                id_q[s]    <= id_q[s-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_decode
            assign read_valid_o[gi] = valid_q[LAST] && (id_q[LAST] == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin owner-based arbiter in front of the single SRAM controller,
// with optional burst preemption and read-data routing by tag.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 0
) (
    input  logic                                  CLOCK_50_I,
    input  logic                                  Reset,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ-1:0]                    req_we_n,
    input  logic [NUM_REQ-1:0][SRAM_ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ-1:0][SRAM_DATA_W-1:0]   req_write_data,
    output logic [NUM_REQ-1:0]                    grant,
    output logic [NUM_REQ-1:0]                    read_valid,
    output logic [SRAM_DATA_W-1:0]                read_data,
    output logic [SRAM_ADDR_W-1:0]                SRAM_address,
    output logic [SRAM_DATA_W-1:0]                SRAM_write_data,
    output logic                                  SRAM_we_n,
    input  logic [SRAM_DATA_W-1:0]                SRAM_read_data
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NUM_REQ - 1);

    arb_state_type          state_q, state_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [SRAM_ADDR_W-1:0] last_addr_q, last_addr_d;

    logic [MAX_REQ-1:0]     req_ext;
    logic [PTR_W-1:0]       pick;
    logic [NUM_REQ-1:0]     owner_onehot;
    logic                   owner_req;
    logic                   others_req;
    logic                   any_req;
    logic                   preempt;
    logic                   access;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
    end

    assign pick = PTR_W'(rr_pick(req_ext, 3'(rr_ptr_q), NUM_REQ));

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign owner_onehot[gi] = (owner_q == PTR_W'(gi));
        end
    endgenerate

    assign owner_req  = req[owner_q];
    assign others_req = |(req & ~owner_onehot);
    assign any_req    = |req;

    // A saturated burst yields only when someone else is waiting; that cycle is not an access.
    assign preempt = (MAX_BURST != 0) && (burst_cnt_q == CNT_MAX) && others_req;
    assign access  = (state_q == ARB_OWN) && owner_req && !preempt;

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            last_addr_q <= last_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        last_addr_d = last_addr_q;
        if (access) begin
            last_addr_d = req_address[owner_q];
        end
        case (state_q)
            ARB_IDLE, ARB_SWITCH: begin
                if (any_req) begin
                    state_d     = ARB_OWN;
                    owner_d     = pick;
                    burst_cnt_d = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_OWN: begin
                if (access) begin
                    if (burst_cnt_q != CNT_MAX) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else begin
                    state_d  = ARB_SWITCH;
                    rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant           = '0;
        SRAM_address    = last_addr_q;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        if (state_q == ARB_OWN) begin
            grant = owner_onehot;
        end
        if (access) begin
            SRAM_address    = req_address[owner_q];
            SRAM_write_data = req_write_data[owner_q];
            SRAM_we_n       = req_we_n[owner_q];
        end
    end

    assign read_data = SRAM_read_data;

    sram_read_tag_pipe #(
        .NUM_REQ      (NUM_REQ),
        .READ_LATENCY (READ_LATENCY),
        .ID_W         (PTR_W)
    ) u_tag_pipe (
        .clk_i        (CLOCK_50_I),
        .srst_i       (Reset),
        .issue_i      (access && req_we_n[owner_q]),
        .id_i         (owner_q),
        .read_valid_o (read_valid)
    );

endmodule
